// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the fetch (IF)
// and load/store (LS) ports; LS has priority, IF is forced after STARVE_LIMIT losses.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        IF_req,
  input  logic [31:0] IF_addr,
  output logic        IF_ack,
  output logic [31:0] IF_rdata,
  input  logic        LS_req,
  input  logic        LS_we,
  input  logic [31:0] LS_addr,
  input  logic [31:0] LS_wdata,
  input  logic [1:0]  LS_length,
  input  logic        LS_signed,
  output logic        LS_ack,
  output logic [31:0] LS_rdata,
  output logic        M_en,
  output logic        M_we,
  output logic [31:0] M_addr,
  output logic [31:0] M_wdata,
  output logic [1:0]  M_length,
  output logic        M_signed,
  input  logic [31:0] M_rdata,
  output logic        busy,
  output logic        grant_owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT_L    = 4'(MEM_LATENCY);
  localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);

  state_t      state_q;
  logic [3:0]  starve_q;
  logic [3:0]  wait_q;
  logic        owner_q;
  logic        busy_q;
  logic        if_ack_q;
  logic        ls_ack_q;
  logic [31:0] if_rdata_q;
  logic [31:0] ls_rdata_q;
  logic        m_en_q;
  logic        m_we_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic [1:0]  m_length_q;
  logic        m_signed_q;
  logic        pick_if;

  always_comb begin
    pick_if = IF_req && (!LS_req || (starve_q == STARVE_L));
  end

  // The M_* registers double as the latched request fields, so the memory sees
  // the access in the ISSUE cycle straight after the grant.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      wait_q     <= '0;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_length_q <= '0;
      m_signed_q <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      ls_ack_q <= 1'b0;
      m_en_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (IF_req || LS_req) begin
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
            m_en_q  <= 1'b1;
            owner_q <= !pick_if;
            if (pick_if) begin
              m_we_q     <= 1'b0;
              m_addr_q   <= IF_addr;
              m_length_q <= 2'b11;
              m_signed_q <= 1'b0;
              starve_q   <= '0;
            end else begin
              m_we_q     <= LS_we;
              m_addr_q   <= LS_addr;
              m_wdata_q  <= LS_wdata;
              m_length_q <= LS_length;
              m_signed_q <= LS_signed;
              if (!IF_req) begin
                starve_q <= '0;
              end else if (starve_q != STARVE_L) begin
                starve_q <= starve_q + 4'd1;
              end
            end
          end
        end
        S_ISSUE: begin
          wait_q  <= LAT_L;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wait_q <= wait_q - 4'd1;
          if (wait_q == 4'd1) begin
            state_q <= S_RESP;
            if (owner_q) begin
              ls_rdata_q <= m_we_q ? '0 : M_rdata;
              ls_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= M_rdata;
              if_ack_q   <= 1'b1;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign IF_ack      = if_ack_q;
  assign IF_rdata    = if_rdata_q;
  assign LS_ack      = ls_ack_q;
  assign LS_rdata    = ls_rdata_q;
  assign M_en        = m_en_q;
  assign M_we        = m_we_q;
  assign M_addr      = m_addr_q;
  assign M_wdata     = m_wdata_q;
  assign M_length    = m_length_q;
  assign M_signed    = m_signed_q;
  assign busy        = busy_q;
  assign grant_owner = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, directed scenarios, a MEM_LATENCY=3 instance and randomized traffic.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int LAT  = 1;
  localparam int SLIM = 4;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        IF_req;
  logic [31:0] IF_addr;
  logic        IF_ack;
  logic [31:0] IF_rdata;
  logic        LS_req;
  logic        LS_we;
  logic [31:0] LS_addr;
  logic [31:0] LS_wdata;
  logic [1:0]  LS_length;
  logic        LS_signed;
  logic        LS_ack;
  logic [31:0] LS_rdata;
  logic        M_en;
  logic        M_we;
  logic [31:0] M_addr;
  logic [31:0] M_wdata;
  logic [1:0]  M_length;
  logic        M_signed;
  logic [31:0] M_rdata;
  logic        busy;
  logic        grant_owner;

  // second instance, MEM_LATENCY=3, fetch traffic only
  logic        IF_req3;
  logic [31:0] IF_addr3;
  logic        IF_ack3;
  logic [31:0] IF_rdata3;
  logic        zero1;
  logic [31:0] zero32;
  logic [1:0]  zero2;
  logic        LS_ack3;
  logic [31:0] LS_rdata3;
  logic        M_en3;
  logic        M_we3;
  logic [31:0] M_addr3;
  logic [31:0] M_wdata3;
  logic [1:0]  M_length3;
  logic        M_signed3;
  logic        busy3;
  logic        grant_owner3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_active = 1'b0;
  int          t_grant = -100;
  int          t_en = -100;
  int          t_ack = -100;
  bit          m_owner = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rd = '0;
  bit          m_we = 1'b0;
  bit          m_sgn = 1'b0;
  logic [1:0]  m_len = '0;
  logic [31:0] e_if_rd = '0;
  logic [31:0] e_ls_rd = '0;
  bit          e_go = 1'b0;
  int          starve = 0;

  function automatic logic [31:0] rdfn(input int c);
    return 32'(c) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  always #5 SYS_clk = ~SYS_clk;
  always @(posedge SYS_clk) cyc <= cyc + 1;
  assign M_rdata = rdfn(cyc);

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .IF_req(IF_req), .IF_addr(IF_addr), .IF_ack(IF_ack), .IF_rdata(IF_rdata),
    .LS_req(LS_req), .LS_we(LS_we), .LS_addr(LS_addr), .LS_wdata(LS_wdata),
    .LS_length(LS_length), .LS_signed(LS_signed), .LS_ack(LS_ack), .LS_rdata(LS_rdata),
    .M_en(M_en), .M_we(M_we), .M_addr(M_addr), .M_wdata(M_wdata),
    .M_length(M_length), .M_signed(M_signed), .M_rdata(M_rdata),
    .busy(busy), .grant_owner(grant_owner)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(SLIM)) u_lat3 (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .IF_req(IF_req3), .IF_addr(IF_addr3), .IF_ack(IF_ack3), .IF_rdata(IF_rdata3),
    .LS_req(zero1), .LS_we(zero1), .LS_addr(zero32), .LS_wdata(zero32),
    .LS_length(zero2), .LS_signed(zero1), .LS_ack(LS_ack3), .LS_rdata(LS_rdata3),
    .M_en(M_en3), .M_we(M_we3), .M_addr(M_addr3), .M_wdata(M_wdata3),
    .M_length(M_length3), .M_signed(M_signed3), .M_rdata(M_rdata),
    .busy(busy3), .grant_owner(grant_owner3)
  );

  // Compare the main DUT against the model for the current cycle; the owner
  // drops its request in its ack cycle.
  task automatic check_cycle();
    int k;
    bit e_men, e_busy, e_ifack, e_lsack;
    @(negedge SYS_clk);
    k = cyc;
    e_men   = m_active && (k == t_en);
    e_busy  = m_active && (k > t_grant) && (k <= t_ack);
    e_ifack = m_active && (k == t_ack) && !m_owner;
    e_lsack = m_active && (k == t_ack) && m_owner;
    if (e_ifack) e_if_rd = m_rd;
    if (e_lsack) e_ls_rd = m_rd;
    checks++;
    if (M_en !== e_men) begin errors++; $display("FAIL m_en cyc=%0d got=%b exp=%b", k, M_en, e_men); end
    checks++;
    if (busy !== e_busy) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", k, busy, e_busy); end
    checks++;
    if (IF_ack !== e_ifack) begin errors++; $display("FAIL if_ack cyc=%0d got=%b exp=%b", k, IF_ack, e_ifack); end
    checks++;
    if (LS_ack !== e_lsack) begin errors++; $display("FAIL ls_ack cyc=%0d got=%b exp=%b", k, LS_ack, e_lsack); end
    checks++;
    if (IF_rdata !== e_if_rd) begin errors++; $display("FAIL if_rdata cyc=%0d got=%h exp=%h", k, IF_rdata, e_if_rd); end
    checks++;
    if (LS_rdata !== e_ls_rd) begin errors++; $display("FAIL ls_rdata cyc=%0d got=%h exp=%h", k, LS_rdata, e_ls_rd); end
    checks++;
    if (grant_owner !== e_go) begin errors++; $display("FAIL grant_owner cyc=%0d got=%b exp=%b", k, grant_owner, e_go); end
    if (e_men) begin
      checks++;
      if (M_addr !== m_addr) begin errors++; $display("FAIL m_addr cyc=%0d got=%h exp=%h", k, M_addr, m_addr); end
      checks++;
      if (M_we !== m_we) begin errors++; $display("FAIL m_we cyc=%0d got=%b exp=%b", k, M_we, m_we); end
      checks++;
      if (M_length !== m_len) begin errors++; $display("FAIL m_length cyc=%0d got=%b exp=%b", k, M_length, m_len); end
      checks++;
      if (M_signed !== m_sgn) begin errors++; $display("FAIL m_signed cyc=%0d got=%b exp=%b", k, M_signed, m_sgn); end
      if (m_we) begin
        checks++;
        if (M_wdata !== m_wdata) begin errors++; $display("FAIL m_wdata cyc=%0d got=%h exp=%h", k, M_wdata, m_wdata); end
      end
    end
    if (e_ifack) IF_req = 1'b0;
    if (e_lsack) LS_req = 1'b0;
  endtask

  // Apply the arbitration rules to the inputs about to be sampled this cycle.
  task automatic commit_cycle();
    int k;
    bit pick_if;
    k = cyc;
    if (SYS_reset) begin
      m_active = 1'b0; starve = 0; e_if_rd = '0; e_ls_rd = '0; e_go = 1'b0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0; m_len = '0; m_sgn = 1'b0;
    end else if (m_active) begin
      if (k >= t_ack) m_active = 1'b0;
    end else if (IF_req || LS_req) begin
      pick_if  = IF_req && (!LS_req || starve == SLIM);
      m_active = 1'b1;
      t_grant  = k;
      t_en     = k + 1;
      t_ack    = k + LAT + 2;
      m_owner  = !pick_if;
      e_go     = m_owner;
      if (pick_if) begin
        m_addr = IF_addr; m_we = 1'b0; m_len = 2'b11; m_sgn = 1'b0; starve = 0;
      end else begin
        m_addr = LS_addr; m_we = LS_we; m_wdata = LS_wdata; m_len = LS_length; m_sgn = LS_signed;
        starve = IF_req ? ((starve < SLIM) ? starve + 1 : starve) : 0;
      end
      m_rd = m_we ? 32'h0 : rdfn(k + 1 + LAT);
    end
  endtask

  task automatic cycle();
    check_cycle();
    commit_cycle();
  endtask

  task automatic test_reset();
    SYS_reset = 1'b1; IF_req = 1'b1; LS_req = 1'b1;
    commit_cycle();
    check_cycle();
    commit_cycle();
    check_cycle();
    checks++;
    if (M_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr got=%h exp=0", M_addr); end
    SYS_reset = 1'b0; IF_req = 1'b0; LS_req = 1'b0;
    commit_cycle();
  endtask

  task automatic test_if_basic();
    int k0, en_at, ack_at;
    en_at = -1; ack_at = -1;
    check_cycle();
    IF_req = 1'b1; IF_addr = 32'h100;
    commit_cycle();
    k0 = cyc;
    for (int i = 1; i <= 6; i++) begin
      check_cycle();
      if (M_en === 1'b1 && en_at < 0) en_at = cyc - k0;
      if (IF_ack === 1'b1 && ack_at < 0) ack_at = cyc - k0;
      commit_cycle();
    end
    checks++;
    if (en_at !== 1) begin errors++; $display("FAIL if_basic_en_cycle got=%0d exp=1", en_at); end
    checks++;
    if (ack_at !== 3) begin errors++; $display("FAIL if_basic_ack_cycle got=%0d exp=3", ack_at); end
  endtask

  task automatic test_simultaneous();
    int k0, ls_at, if_at;
    ls_at = -1; if_at = -1;
    check_cycle();
    IF_req = 1'b1; IF_addr = 32'h0000_0A00;
    LS_req = 1'b1; LS_we = 1'b0; LS_addr = 32'h200; LS_length = 2'b01; LS_signed = 1'b1;
    commit_cycle();
    k0 = cyc;
    for (int i = 1; i <= 9; i++) begin
      check_cycle();
      if (LS_ack === 1'b1 && ls_at < 0) ls_at = cyc - k0;
      if (IF_ack === 1'b1 && if_at < 0) if_at = cyc - k0;
      commit_cycle();
    end
    checks++;
    if (ls_at !== 3) begin errors++; $display("FAIL simul_ls_ack got=%0d exp=3", ls_at); end
    checks++;
    if (if_at !== 7) begin errors++; $display("FAIL simul_if_ack got=%0d exp=7", if_at); end
  endtask

  task automatic test_starvation();
    int ls_acks, before_if;
    bit if_done;
    ls_acks = 0; before_if = -1; if_done = 1'b0;
    check_cycle();
    IF_req = 1'b1; IF_addr = 32'h0000_0300;
    LS_req = 1'b1; LS_we = 1'b0; LS_addr = $urandom; LS_length = 2'b11; LS_signed = 1'b0;
    commit_cycle();
    for (int i = 0; i < 30; i++) begin
      check_cycle();
      if (IF_ack === 1'b1 && !if_done) begin if_done = 1'b1; before_if = ls_acks; end
      if (LS_ack === 1'b1) ls_acks++;
      if (!if_done && LS_req == 1'b0) begin
        LS_req = 1'b1; LS_addr = $urandom; LS_length = 2'($urandom_range(1, 3));
      end
      commit_cycle();
    end
    checks++;
    if (before_if !== SLIM) begin errors++; $display("FAIL starve_ls_before_if got=%0d exp=%0d", before_if, SLIM); end
    // with the counter cleared, a fresh simultaneous pair goes to LS again
    check_cycle();
    IF_req = 1'b1; LS_req = 1'b1;
    commit_cycle();
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (ls_acks < 5) begin errors++; $display("FAIL starve_total_ls got=%0d exp>=5", ls_acks); end
  endtask

  task automatic test_store();
    logic [31:0] if_keep;
    check_cycle();
    if_keep = IF_rdata;
    LS_req = 1'b1; LS_we = 1'b1; LS_addr = 32'h40; LS_wdata = 32'h1234_5678;
    LS_length = 2'b10; LS_signed = 1'b0;
    commit_cycle();
    for (int i = 1; i <= 6; i++) begin
      check_cycle();
      if (M_en === 1'b1) begin
        checks++;
        if (M_we !== 1'b1 || M_wdata !== 32'h1234_5678 || M_length !== 2'b10) begin
          errors++; $display("FAIL store_issue got we=%b wdata=%h len=%b exp we=1 wdata=12345678 len=10", M_we, M_wdata, M_length);
        end
      end
      if (LS_ack === 1'b1) begin
        checks++;
        if (LS_rdata !== 32'h0) begin errors++; $display("FAIL store_ls_rdata got=%h exp=0", LS_rdata); end
      end
      commit_cycle();
    end
    LS_we = 1'b0;
    checks++;
    if (IF_rdata !== if_keep) begin errors++; $display("FAIL store_if_rdata_held got=%h exp=%h", IF_rdata, if_keep); end
  endtask

  task automatic test_reset_mid();
    int late_acks;
    late_acks = 0;
    check_cycle();
    LS_req = 1'b1; LS_we = 1'b0; LS_addr = $urandom; LS_length = 2'b11; LS_signed = 1'b0;
    commit_cycle();
    cycle();        // ISSUE
    check_cycle();  // WAIT
    SYS_reset = 1'b1; LS_req = 1'b0;
    commit_cycle();
    check_cycle();
    checks++;
    if (busy !== 1'b0 || LS_ack !== 1'b0 || LS_rdata !== 32'h0 || IF_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid_outputs got busy=%b ls_ack=%b ls_rdata=%h if_rdata=%h exp all 0", busy, LS_ack, LS_rdata, IF_rdata);
    end
    SYS_reset = 1'b0;
    commit_cycle();
    for (int i = 0; i < 6; i++) begin
      check_cycle();
      if (LS_ack === 1'b1) late_acks++;
      commit_cycle();
    end
    checks++;
    if (late_acks !== 0) begin errors++; $display("FAIL reset_mid_late_ack got=%0d exp=0", late_acks); end
  endtask

  task automatic test_latency3();
    int k0, en_at, ack_at;
    logic [31:0] a;
    en_at = -1; ack_at = -1; a = $urandom;
    @(negedge SYS_clk);
    IF_req3 = 1'b1; IF_addr3 = a;
    k0 = cyc;
    for (int i = 1; i <= 10; i++) begin
      @(negedge SYS_clk);
      if (M_en3 === 1'b1 && en_at < 0) begin
        en_at = cyc - k0;
        checks++;
        if (M_addr3 !== a || M_length3 !== 2'b11 || M_we3 !== 1'b0 || M_signed3 !== 1'b0 || M_wdata3 !== 32'h0 || busy3 !== 1'b1) begin
          errors++; $display("FAIL lat3_issue got addr=%h len=%b we=%b sgn=%b wdata=%h busy=%b exp addr=%h len=11 we=0 sgn=0 wdata=0 busy=1", M_addr3, M_length3, M_we3, M_signed3, M_wdata3, busy3, a);
        end
      end
      if (IF_ack3 === 1'b1 && ack_at < 0) begin
        ack_at = cyc - k0;
        IF_req3 = 1'b0;
        checks++;
        if (IF_rdata3 !== rdfn(k0 + 1 + 3)) begin errors++; $display("FAIL lat3_rdata got=%h exp=%h", IF_rdata3, rdfn(k0 + 4)); end
      end
      checks++;
      if (LS_ack3 !== 1'b0 || LS_rdata3 !== 32'h0 || grant_owner3 !== 1'b0) begin
        errors++; $display("FAIL lat3_ls_side got ack=%b rdata=%h owner=%b exp 0", LS_ack3, LS_rdata3, grant_owner3);
      end
    end
    checks++;
    if (en_at !== 1) begin errors++; $display("FAIL lat3_en_cycle got=%0d exp=1", en_at); end
    checks++;
    if (ack_at !== 5) begin errors++; $display("FAIL lat3_ack_cycle got=%0d exp=5", ack_at); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      check_cycle();
      if (!IF_req && $urandom_range(0, 2) == 0) begin
        IF_req = 1'b1; IF_addr = $urandom;
      end else if (IF_req && $urandom_range(0, 31) == 0) begin
        IF_req = 1'b0;
      end
      if (!LS_req && $urandom_range(0, 2) == 0) begin
        LS_req = 1'b1; LS_we = 1'($urandom_range(0, 1)); LS_addr = $urandom; LS_wdata = $urandom;
        LS_length = 2'($urandom_range(1, 3)); LS_signed = 1'($urandom_range(0, 1));
      end else if (LS_req && $urandom_range(0, 31) == 0) begin
        LS_req = 1'b0;
      end
      commit_cycle();
    end
    check_cycle();
    IF_req = 1'b0; LS_req = 1'b0;
    commit_cycle();
    for (int i = 0; i < 8; i++) cycle();
  endtask

  initial begin
    IF_req = 1'b0; IF_addr = '0; LS_req = 1'b0; LS_we = 1'b0; LS_addr = '0;
    LS_wdata = '0; LS_length = 2'b11; LS_signed = 1'b0; SYS_reset = 1'b1;
    IF_req3 = 1'b0; IF_addr3 = '0; zero1 = 1'b0; zero32 = '0; zero2 = '0;
    test_reset();
    test_if_basic();
    test_simultaneous();
    test_starvation();
    test_store();
    test_reset_mid();
    test_if_basic();
    test_latency3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
